// File: rtl/alu_pkg.sv
// Shared definitions for the ID/EX ALU control stage: ALU operation codes,
// RV32I major opcodes and the operand-select encodings used by the decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_BNE = 4'b0100,
        ALU_BLT = 4'b0101,
        ALU_BGE = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_SUB = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_SRL = 4'b1011,
        ALU_SLL = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_ZERO = 2'b00,
        SRCA_RS1  = 2'b01,
        SRCA_PC   = 2'b10
    } srca_sel_t;

    typedef enum logic [1:0] {
        SRCB_ZERO = 2'b00,
        SRCB_RS2  = 2'b01,
        SRCB_IMM  = 2'b10
    } srcb_sel_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode of opcode/funct3/funct7[5] into ALU operation,
// operand sources, shift-amount masking and an illegal-instruction flag.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_t    op,
    output srca_sel_t  srca_sel,
    output srcb_sel_t  srcb_sel,
    output logic       shamt_mask,
    output logic       illegal
);

    alu_op_t   op_s;
    srca_sel_t srca_s;
    srcb_sel_t srcb_s;
    logic      mask_s;
    logic      ill_s;

    // Raw decode; the illegal path is cleaned up in the block below.
    always_comb begin
        op_s   = ALU_AND;
        srca_s = SRCA_ZERO;
        srcb_s = SRCB_ZERO;
        mask_s = 1'b0;
        ill_s  = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                srca_s = SRCA_RS1;
                srcb_s = SRCB_RS2;
                case (funct3)
                    F3_ADD: op_s = funct7b5 ? ALU_SUB : ALU_ADD;
                    F3_AND: op_s = ALU_AND;
                    F3_OR:  op_s = ALU_OR;
                    F3_XOR: op_s = ALU_XOR;
                    F3_SLT: op_s = ALU_SLT;
                    F3_SLL: begin
                        op_s   = ALU_SLL;
                        mask_s = 1'b1;
                    end
                    F3_SR: begin
                        op_s   = funct7b5 ? ALU_SRA : ALU_SRL;
                        mask_s = 1'b1;
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_IALU: begin
                srca_s = SRCA_RS1;
                srcb_s = SRCB_IMM;
                case (funct3)
                    F3_ADD: op_s = ALU_ADD;
                    F3_SLT: op_s = ALU_SLT;
                    F3_AND: op_s = ALU_AND;
                    F3_OR:  op_s = ALU_OR;
                    F3_XOR: op_s = ALU_XOR;
                    F3_SLL: begin
                        op_s   = ALU_SLL;
                        mask_s = 1'b1;
                    end
                    F3_SR: begin
                        op_s   = funct7b5 ? ALU_SRA : ALU_SRL;
                        mask_s = 1'b1;
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                srca_s = SRCA_RS1;
                srcb_s = SRCB_RS2;
                case (funct3)
                    F3_BEQ:  op_s = ALU_BEQ;
                    F3_BNE:  op_s = ALU_BNE;
                    F3_BLT:  op_s = ALU_BLT;
                    F3_BGE:  op_s = ALU_BGE;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                op_s   = ALU_ADD;
                srca_s = SRCA_RS1;
                srcb_s = SRCB_IMM;
            end
            OPC_LUI: begin
                op_s   = ALU_ADD;
                srca_s = SRCA_ZERO;
                srcb_s = SRCB_IMM;
            end
            OPC_AUIPC, OPC_JAL: begin
                op_s   = ALU_ADD;
                srca_s = SRCA_PC;
                srcb_s = SRCB_IMM;
            end
            default: ill_s = 1'b1;
        endcase
    end

    // Illegal instructions present op 0000 with both operands forced to zero.
    always_comb begin
        illegal = ill_s;
        if (ill_s) begin
            op         = ALU_AND;
            srca_sel   = SRCA_ZERO;
            srcb_sel   = SRCB_ZERO;
            shamt_mask = 1'b0;
        end else begin
            op         = op_s;
            srca_sel   = srca_s;
            srcb_sel   = srcb_s;
            shamt_mask = mask_s;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX control stage: decodes the instruction, selects ALU operands and holds
// them in a single-entry valid/ready pipeline register with flush support.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    alu_op_t   dec_op_s;
    srca_sel_t dec_srca_sel_s;
    srcb_sel_t dec_srcb_sel_s;
    logic      dec_shamt_mask_s;
    logic      dec_illegal_s;

    logic [DATA_WIDTH-1:0]    srca_s;
    logic [DATA_WIDTH-1:0]    srcb_raw_s;
    logic [DATA_WIDTH-1:0]    srcb_s;
    logic                     in_ready_s;
    logic                     capture_s;

    logic                     valid_r;
    logic [DATA_WIDTH-1:0]    srca_r;
    logic [DATA_WIDTH-1:0]    srcb_r;
    logic [OPCODE_LENGTH-1:0] op_r;
    logic                     illegal_r;

    alu_decoder u_decoder (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op         (dec_op_s),
        .srca_sel   (dec_srca_sel_s),
        .srcb_sel   (dec_srcb_sel_s),
        .shamt_mask (dec_shamt_mask_s),
        .illegal    (dec_illegal_s)
    );

    // Operand A source mux.
    always_comb begin
        case (dec_srca_sel_s)
            SRCA_RS1:  srca_s = rs1_data;
            SRCA_PC:   srca_s = pc;
            SRCA_ZERO: srca_s = {DATA_WIDTH{1'b0}};
            default:   srca_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Operand B source mux; shifts only ever see the low five bits.
    always_comb begin
        case (dec_srcb_sel_s)
            SRCB_RS2:  srcb_raw_s = rs2_data;
            SRCB_IMM:  srcb_raw_s = imm;
            SRCB_ZERO: srcb_raw_s = {DATA_WIDTH{1'b0}};
            default:   srcb_raw_s = {DATA_WIDTH{1'b0}};
        endcase
        if (dec_shamt_mask_s) begin
            srcb_s = {{(DATA_WIDTH-5){1'b0}}, srcb_raw_s[4:0]};
        end else begin
            srcb_s = srcb_raw_s;
        end
    end

    assign in_ready_s = !valid_r || out_ready;
    assign capture_s  = in_valid && in_ready_s && !flush;

    // Pipeline register: flush beats capture, and a stalled entry holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r   <= 1'b0;
            srca_r    <= {DATA_WIDTH{1'b0}};
            srcb_r    <= {DATA_WIDTH{1'b0}};
            op_r      <= {OPCODE_LENGTH{1'b0}};
            illegal_r <= 1'b0;
        end else if (flush) begin
            valid_r   <= 1'b0;
        end else if (capture_s) begin
            valid_r   <= 1'b1;
            srca_r    <= srca_s;
            srcb_r    <= srcb_s;
            op_r      <= OPCODE_LENGTH'(dec_op_s);
            illegal_r <= dec_illegal_s;
        end else if (out_ready) begin
            valid_r   <= 1'b0;
        end else begin
            valid_r   <= valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign SrcA      = srca_r;
    assign SrcB      = srcb_r;
    assign Operation = op_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: directed cases then random traffic,
// checked against a reference model of the RV32I ALU-control rules.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        illegal;

    always #5 clk = ~clk;

    alu_ctrl_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal(illegal)
    );

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b5;
        logic [31:0] r1, r2, im, p;
    } instr_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic started = 1'b0;
    logic model_valid = 1'b0, model_zero = 1'b0;
    logic nxt_valid = 1'b0, nxt_zero = 1'b1;

    function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] im, input logic [31:0] p);
        instr_t i;
        i.opc = opc; i.f3 = f3; i.b5 = b5; i.r1 = r1; i.r2 = r2; i.im = im; i.p = p;
        return i;
    endfunction

    // Reference model: ALU code table by instruction class, shift amounts mod 32.
    function automatic exp_t ref_model(input instr_t i);
        exp_t e;
        int   code;
        bit   shift;
        logic [31:0] a, b;
        code = -1; shift = 0; a = 32'd0; b = 32'd0;
        case (i.opc)
            7'b0110011, 7'b0010011: begin
                a = i.r1;
                b = (i.opc == 7'b0110011) ? i.r2 : i.im;
                case (i.f3)
                    3'd0: code = (i.opc == 7'b0110011 && i.b5) ? 9 : 3;
                    3'd7: code = 0;
                    3'd6: code = 1;
                    3'd4: code = 2;
                    3'd2: code = 7;
                    3'd1: begin code = 12; shift = 1; end
                    3'd5: begin code = i.b5 ? 10 : 11; shift = 1; end
                    default: code = -1;
                endcase
                if (shift) b = b % 32;
            end
            7'b1100011: begin
                a = i.r1; b = i.r2;
                case (i.f3)
                    3'd0: code = 8;
                    3'd1: code = 4;
                    3'd4: code = 5;
                    3'd5: code = 6;
                    default: code = -1;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111: begin code = 3; a = i.r1; b = i.im; end
            7'b0110111: begin code = 3; a = 32'd0; b = i.im; end
            7'b0010111, 7'b1101111: begin code = 3; a = i.p; b = i.im; end
            default: code = -1;
        endcase
        if (code < 0) begin
            e.a = 32'd0; e.b = 32'd0; e.op = 4'd0; e.ill = 1'b1;
        end else begin
            e.a = a; e.b = b; e.op = 4'(code); e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic instr_t rnd_instr();
        logic [6:0] opc;
        case ($urandom_range(0, 11))
            0, 9:    opc = 7'b0110011;
            1:       opc = 7'b0010011;
            2, 10:   opc = 7'b1100011;
            3:       opc = 7'b0000011;
            4:       opc = 7'b0100011;
            5:       opc = 7'b1100111;
            6:       opc = 7'b0110111;
            7:       opc = 7'b0010111;
            8:       opc = 7'b1101111;
            default: opc = 7'($urandom);
        endcase
        return mk(opc, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    endfunction

    // One cycle of stimulus; the model decides what the next edge does.
    task automatic step(input logic iv, input instr_t ins, input logic fl,
                        input logic rst, input logic ordy);
        logic exp_ready;
        @(posedge clk);
        #1;
        model_valid = nxt_valid;
        model_zero  = nxt_zero;
        in_valid = iv; opcode = ins.opc; funct3 = ins.f3; funct7b5 = ins.b5;
        rs1_data = ins.r1; rs2_data = ins.r2; imm = ins.im; pc = ins.p;
        flush = fl; reset = rst; out_ready = ordy;
        started = 1'b1;
        exp_ready = !model_valid || ordy;
        if (rst) begin
            nxt_valid = 1'b0; nxt_zero = 1'b1;
        end else if (fl) begin
            nxt_valid = 1'b0;
        end else if (iv && exp_ready) begin
            q.push_back(ref_model(ins));
            nxt_valid = 1'b1; nxt_zero = 1'b0;
        end else if (ordy) begin
            nxt_valid = 1'b0;
        end else begin
            nxt_valid = model_valid;
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle and retires entries that leave.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (out_valid !== model_valid) begin
                errors++;
                $display("FAIL out_valid: got %b want %b at %0t", out_valid, model_valid, $time);
            end
            checks++;
            if (in_ready !== (!model_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b want %b at %0t", in_ready, !model_valid || out_ready, $time);
            end
            if (model_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: empty queue while output expected at %0t", $time);
                end else if (SrcA !== q[0].a || SrcB !== q[0].b ||
                             Operation !== q[0].op || illegal !== q[0].ill) begin
                    errors++;
                    $display("FAIL data: got A=%h B=%h op=%h ill=%b want A=%h B=%h op=%h ill=%b at %0t",
                             SrcA, SrcB, Operation, illegal,
                             q[0].a, q[0].b, q[0].op, q[0].ill, $time);
                end
                if ((out_ready || flush || reset) && q.size() > 0) void'(q.pop_front());
            end else if (model_zero) begin
                checks++;
                if (SrcA !== 32'd0 || SrcB !== 32'd0 || Operation !== 4'd0 || illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_vals: got A=%h B=%h op=%h ill=%b want all zero at %0t",
                             SrcA, SrcB, Operation, illegal, $time);
                end
            end
        end
    end

    initial begin
        instr_t nop_i, blt_i, add_i;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; pc = 32'd0;
        nop_i = mk(7'b0010011, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        blt_i = mk(7'b1100011, 3'b100, 1'b0, 32'd1, 32'd2, 32'h55, 32'h40);
        add_i = mk(7'b0110011, 3'b000, 1'b0, 32'd7, 32'd8, 32'd0, 32'd0);

        step(1'b0, nop_i, 1'b0, 1'b1, 1'b1);
        step(1'b0, nop_i, 1'b0, 1'b0, 1'b1);
        // SUB, SRAI, SRLI
        step(1'b1, mk(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(7'b0010011, 3'b101, 1'b1, 32'hdead, 32'd0, 32'h0000_0405, 32'd0), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(7'b0010011, 3'b101, 1'b0, 32'hdead, 32'd0, 32'h0000_0405, 32'd0), 1'b0, 1'b0, 1'b1);
        // BLT then a three-cycle stall with new traffic pending
        step(1'b1, blt_i, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, add_i, 1'b0, 1'b0, 1'b0);
        step(1'b1, add_i, 1'b0, 1'b0, 1'b1);
        // AUIPC and LUI
        step(1'b1, mk(7'b0010111, 3'd0, 1'b0, 32'h11, 32'h22, 32'h2000, 32'h100), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(7'b0110111, 3'd0, 1'b0, 32'h11, 32'h22, 32'h2000, 32'h100), 1'b0, 1'b0, 1'b1);
        // Flush while holding, with a new instruction offered
        step(1'b1, add_i, 1'b0, 1'b0, 1'b0);
        step(1'b1, blt_i, 1'b1, 1'b0, 1'b0);
        step(1'b0, nop_i, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of a stall
        step(1'b1, blt_i, 1'b0, 1'b0, 1'b0);
        step(1'b1, add_i, 1'b0, 1'b0, 1'b0);
        step(1'b1, add_i, 1'b0, 1'b1, 1'b0);
        step(1'b0, nop_i, 1'b0, 1'b0, 1'b0);
        // Illegal encodings
        step(1'b1, mk(7'b1111111, 3'd0, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(7'b1100011, 3'b010, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(7'b0110011, 3'b011, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8), 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 3) != 0), rnd_instr(), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7));
        end

        for (int k = 0; k < 3; k++) step(1'b0, nop_i, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
